gl_triangle_feeder: RTL and testbench

- Producer end of the rasterizer's triangle interface.
- Accepts a stream of transformed vertices (position + colour), one per handshake, and assembles every three consecutive vertices into a triangle.
- Buffers up to DEPTH triangles and presents the head triangle to the rasterizer using the fifo_ready / raster_ready protocol.
- Sits between the vertex transform stage and the rasterizer.

---
 rtl/gl_types.sv | 21 ++
 rtl/gl_tri_fifo_mem.sv | 25 ++
 rtl/gl_triangle_feeder.sv | 128 ++++++++++++
 tb/tb_gl_triangle_feeder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gl_types.sv
// rtl/gl_types.sv - shared widths, field slices and output FSM encoding for the triangle path
package gl_types;
  localparam int VERTEX_TYPE_SIZE = 96;
  localparam int COLOR_TYPE_SIZE  = 96;

  localparam int X_MSB = 95, X_LSB = 64;
  localparam int Y_MSB = 63, Y_LSB = 32;
  localparam int Z_MSB = 31, Z_LSB = 0;
  localparam int R_MSB = 95, R_LSB = 64;
  localparam int G_MSB = 63, G_LSB = 32;
  localparam int B_MSB = 31, B_LSB = 0;

  localparam int VC_SIZE      = VERTEX_TYPE_SIZE + COLOR_TYPE_SIZE;
  localparam int TRI_REC_SIZE = 3 * VC_SIZE;

  typedef enum logic [1:0] {
    OUT_IDLE    = 2'd0,
    OUT_PRESENT = 2'd1,
    OUT_BUSY    = 2'd2
  } out_state_e;
endpackage

// File: rtl/gl_tri_fifo_mem.sv
// rtl/gl_tri_fifo_mem.sv - DEPTH x WIDTH register array, one write port, combinational read
module gl_tri_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/gl_triangle_feeder.sv
// rtl/gl_triangle_feeder.sv - assembles vertex triples into triangles, queues them,
// and presents the head triangle to the rasterizer with a one-cycle fifo_ready strobe
module gl_triangle_feeder
  import gl_types::*;
#(
  parameter int VERTEX_TYPE_SIZE = gl_types::VERTEX_TYPE_SIZE,
  parameter int COLOR_TYPE_SIZE  = gl_types::COLOR_TYPE_SIZE,
  parameter int DEPTH            = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [VERTEX_TYPE_SIZE-1:0] in_vertex,
  input  logic [COLOR_TYPE_SIZE-1:0]  in_color,
  input  logic                        flush,
  output logic                        fifo_ready,
  input  logic                        raster_ready,
  output logic [VERTEX_TYPE_SIZE-1:0] vertex_out1,
  output logic [VERTEX_TYPE_SIZE-1:0] vertex_out2,
  output logic [VERTEX_TYPE_SIZE-1:0] vertex_out3,
  output logic [COLOR_TYPE_SIZE-1:0]  color_out1,
  output logic [COLOR_TYPE_SIZE-1:0]  color_out2,
  output logic [COLOR_TYPE_SIZE-1:0]  color_out3,
  output logic [$clog2(DEPTH):0]      level
);
  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  localparam int VC  = VERTEX_TYPE_SIZE + COLOR_TYPE_SIZE;
  localparam int REC = 3 * VC;

  logic [1:0]     asm_cnt_q, asm_cnt_d;
  logic [VC-1:0]  stage0_q, stage0_d, stage1_q, stage1_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic [REC-1:0] out_rec_q, out_rec_d, head_rec;
  logic           raster_ready_q, raster_ready_d;
  out_state_e     state_q, state_d;
  logic [VC-1:0]  in_word;
  logic           accept, push, done;

  assign in_word  = {in_vertex, in_color};
  // Full-stall only blocks the vertex that would complete a triangle.
  assign in_ready = reset_n && !(asm_cnt_q == 2'd2 && level_q == LW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && !flush && asm_cnt_q == 2'd2;
  assign done     = state_q == OUT_BUSY && raster_ready && !raster_ready_q;

  always_comb begin
    asm_cnt_d      = asm_cnt_q;
    stage0_d       = stage0_q;
    stage1_d       = stage1_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    raster_ready_d = raster_ready;
    if (flush) begin
      asm_cnt_d = 2'd0;
    end else if (accept) begin
      asm_cnt_d = (asm_cnt_q == 2'd2) ? 2'd0 : asm_cnt_q + 2'd1;
      if (asm_cnt_q == 2'd0) stage0_d = in_word;
      if (asm_cnt_q == 2'd1) stage1_d = in_word;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (done) rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + LW'(push) - LW'(done);
  end

  always_comb begin
    state_d   = state_q;
    out_rec_d = out_rec_q;
    case (state_q)
      OUT_IDLE: begin
        if (level_q != '0) begin
          out_rec_d = head_rec;
          state_d   = OUT_PRESENT;
        end
      end
      OUT_PRESENT: state_d = OUT_BUSY;
      OUT_BUSY:    if (done) state_d = OUT_IDLE;
      default:     state_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_cnt_q      <= '0;
      stage0_q       <= '0;
      stage1_q       <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      out_rec_q      <= '0;
      raster_ready_q <= 1'b0;
      state_q        <= OUT_IDLE;
    end else begin
      asm_cnt_q      <= asm_cnt_d;
      stage0_q       <= stage0_d;
      stage1_q       <= stage1_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      out_rec_q      <= out_rec_d;
      raster_ready_q <= raster_ready_d;
      state_q        <= state_d;
    end
  end

  gl_tri_fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(REC)
  ) u_mem (
    .clk    (clk),
    .wr_en  (push),
    .wr_addr(wr_ptr_q),
    .wr_data({stage0_q, stage1_q, in_word}),
    .rd_addr(rd_ptr_q),
    .rd_data(head_rec)
  );

  assign fifo_ready  = state_q == OUT_PRESENT;
  assign level       = level_q;
  assign vertex_out1 = out_rec_q[REC-1 -: VERTEX_TYPE_SIZE];
  assign color_out1  = out_rec_q[REC-VERTEX_TYPE_SIZE-1 -: COLOR_TYPE_SIZE];
  assign vertex_out2 = out_rec_q[2*VC-1 -: VERTEX_TYPE_SIZE];
  assign color_out2  = out_rec_q[2*VC-VERTEX_TYPE_SIZE-1 -: COLOR_TYPE_SIZE];
  assign vertex_out3 = out_rec_q[VC-1 -: VERTEX_TYPE_SIZE];
  assign color_out3  = out_rec_q[COLOR_TYPE_SIZE-1:0];
endmodule

// File: tb/tb_gl_triangle_feeder.sv
// tb/tb_gl_triangle_feeder.sv - randomized and directed bench for gl_triangle_feeder
module tb_gl_triangle_feeder;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [95:0] v;
    logic [95:0] c;
  } vtx_t;
  typedef struct packed {
    vtx_t v1;
    vtx_t v2;
    vtx_t v3;
  } tri_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [95:0] in_vertex = '0;
  logic [95:0] in_color = '0;
  logic        flush = 1'b0;
  logic        fifo_ready;
  logic        raster_ready = 1'b0;
  logic [95:0] vertex_out1, vertex_out2, vertex_out3;
  logic [95:0] color_out1, color_out2, color_out3;
  logic [2:0]  level;

  gl_triangle_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vertex(in_vertex), .in_color(in_color), .flush(flush),
    .fifo_ready(fifo_ready), .raster_ready(raster_ready),
    .vertex_out1(vertex_out1), .vertex_out2(vertex_out2), .vertex_out3(vertex_out3),
    .color_out1(color_out1), .color_out2(color_out2), .color_out3(color_out3),
    .level(level)
  );

  always #5 clk = ~clk;

  // Reference: pending vertices, stored triangles (head = one being shown), presentation phase
  vtx_t pend[$];
  tri_t tq[$];
  vtx_t src[$];
  tri_t shown;
  int   phase;
  logic rr_prev;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return !(pend.size() == 2 && tq.size() == DEPTH);
  endfunction

  task automatic check_outputs();
    chk("in_ready", 96'(in_ready), 96'(m_ready()));
    chk("fifo_ready", 96'(fifo_ready), 96'(phase == 1));
    chk("level", 96'(level), 96'(tq.size()));
    chk("vertex_out1", vertex_out1, shown.v1.v);
    chk("color_out1", color_out1, shown.v1.c);
    chk("vertex_out2", vertex_out2, shown.v2.v);
    chk("color_out2", color_out2, shown.v2.c);
    chk("vertex_out3", vertex_out3, shown.v3.v);
    chk("color_out3", color_out3, shown.v3.c);
  endtask

  task automatic tick();
    bit   acc, rise, fl;
    int   n;
    vtx_t x;
    tri_t t;
    acc  = in_valid && m_ready();
    rise = raster_ready && !rr_prev;
    fl   = flush;
    n    = tq.size();
    x    = '{v: in_vertex, c: in_color};
    @(posedge clk);
    rr_prev = raster_ready;
    if (phase == 2 && rise) begin
      void'(tq.pop_front());
      phase = 0;
    end else if (phase == 1) begin
      phase = 2;
    end else if (phase == 0 && n > 0) begin
      phase = 1;
      shown = tq[0];
    end
    if (fl) begin
      pend.delete();
    end else if (acc) begin
      if (pend.size() == 2) begin
        t = '{v1: pend[0], v2: pend[1], v3: x};
        tq.push_back(t);
        pend.delete();
      end else begin
        pend.push_back(x);
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic push_n(input int n, input int budget, output int got);
    bit a;
    got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      in_valid  = 1'b1;
      in_vertex = src[0].v;
      in_color  = src[0].c;
      a = m_ready();
      tick();
      if (a) begin
        got++;
        void'(src.pop_front());
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic add_rand(input int n);
    for (int i = 0; i < n; i++)
      src.push_back('{v: {$urandom, $urandom, $urandom}, c: {$urandom, $urandom, $urandom}});
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && !(tq.size() == 0 && phase == 0); i++) begin
      raster_ready = (i % 4 == 3);
      tick();
    end
    raster_ready = 1'b0;
    tick();
    chk("drain_level", 96'(level), 96'(0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    raster_ready = 1'b0;
    #1;
    pend.delete();
    tq.delete();
    phase = 0;
    shown = '0;
    rr_prev = 1'b0;
    chk("rst_in_ready", 96'(in_ready), 96'(0));
    chk("rst_fifo_ready", 96'(fifo_ready), 96'(0));
    chk("rst_level", 96'(level), 96'(0));
    chk("rst_vertex_out1", vertex_out1, 96'(0));
    chk("rst_color_out3", color_out3, 96'(0));
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1 chk("rel_in_ready", 96'(in_ready), 96'(1));
  endtask

  initial begin
    int got;
    #1 do_reset();

    // Known x coordinates, full presentation and release
    src.push_back('{v: {32'h3F800000, 32'h11111111, 32'h22222222}, c: 96'h1});
    src.push_back('{v: {32'h40000000, 32'h33333333, 32'h44444444}, c: 96'h2});
    src.push_back('{v: {32'h40400000, 32'h55555555, 32'h66666666}, c: 96'h3});
    push_n(3, 3, got);
    chk("t1_pushed", 96'(got), 96'(3));
    chk("t1_level", 96'(level), 96'(1));
    for (int i = 0; i < 4; i++) tick();
    chk("t1_x1", 96'(vertex_out1[95:64]), 96'(32'h3F800000));
    chk("t1_x2", 96'(vertex_out2[95:64]), 96'(32'h40000000));
    chk("t1_x3", 96'(vertex_out3[95:64]), 96'(32'h40400000));
    raster_ready = 1'b1;
    tick();
    raster_ready = 1'b0;
    tick();
    chk("t1_level_after", 96'(level), 96'(0));

    // Overfill: 15th vertex must stall until a triangle retires
    add_rand(15);
    push_n(14, 30, got);
    chk("t2_pushed", 96'(got), 96'(14));
    push_n(1, 3, got);
    chk("t2_held", 96'(got), 96'(0));
    raster_ready = 1'b1;
    push_n(1, 1, got);
    chk("t2_done_edge", 96'(got), 96'(0));
    raster_ready = 1'b0;
    push_n(1, 1, got);
    chk("t2_accept", 96'(got), 96'(1));
    drain();

    // Flush drops the partial triangle and the vertex accepted with it
    add_rand(2);
    push_n(1, 3, got);
    in_valid = 1'b1;
    in_vertex = src[0].v;
    in_color = src[0].c;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    void'(src.pop_front());
    add_rand(3);
    push_n(3, 6, got);
    chk("t3_level", 96'(level), 96'(1));
    drain();

    // Level-held raster_ready retires only one triangle
    add_rand(9);
    push_n(9, 12, got);
    raster_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("t4_level", 96'(level), 96'(2));
    raster_ready = 1'b0;
    tick();
    drain();

    // Push and pop on the same edge
    add_rand(3);
    push_n(3, 4, got);
    for (int i = 0; i < 3; i++) tick();
    add_rand(3);
    push_n(2, 4, got);
    raster_ready = 1'b1;
    push_n(1, 1, got);
    chk("t5_push", 96'(got), 96'(1));
    chk("t5_level", 96'(level), 96'(1));
    raster_ready = 1'b0;
    drain();

    // Asynchronous reset while busy with a partial triangle pending
    add_rand(10);
    push_n(10, 14, got);
    tick();
    tick();
    chk("t6_level_pre", 96'(level), 96'(3));
    do_reset();
    src.delete();
    add_rand(3);
    push_n(3, 4, got);
    chk("t6_fresh", 96'(level), 96'(1));
    drain();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      in_valid     = ($urandom % 3) != 0;
      in_vertex    = {$urandom, $urandom, $urandom};
      in_color     = {$urandom, $urandom, $urandom};
      flush        = ($urandom % 40) == 0;
      if (($urandom % 3) == 0) raster_ready = ~raster_ready;
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    raster_ready = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
